// File: rtl/pingpong_block_bram.sv
// Double-buffered block RAM between the 4x4 residual producer and the CAVLC scanner.
// The writer fills one bank in raster order while the reader drains the other bank in raster or zig-zag order.
module pingpong_block_bram #(
  parameter int WIDTH     = 9,
  parameter int DEPTH     = 16,
  parameter int addrWIDTH = 4,
  parameter bit ZIGZAG    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_overflow,
  input  logic             rd_en,
  input  logic             zz_mode,
  output logic             blk_avail,
  output logic [1:0]       bank_cnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last
);

  // Zig-zag scan positions, one nibble per scan index (index 0 in the low nibble).
  localparam logic [63:0] ZZ_TAB = 64'hFEB7_ADC9_6325_8410;

  logic [WIDTH-1:0]     mem [2*DEPTH];
  logic [1:0]           full;
  logic                 wbank;
  logic                 rbank;
  logic [addrWIDTH-1:0] wcnt;
  logic [addrWIDTH-1:0] rcnt;
  logic                 zz_lat;

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 wr_end;
  logic                 rd_end;
  logic                 zz;
  logic [addrWIDTH-1:0] raddr;
  logic [1:0]           full_set;
  logic [1:0]           full_clr;

  function automatic logic [addrWIDTH-1:0] zz_addr(input logic [addrWIDTH-1:0] idx);
    logic [3:0] pos;
    pos = ZZ_TAB[4*int'(idx) +: 4];
    return addrWIDTH'(pos);
  endfunction

  assign wr_ready  = !full[wbank];
  assign blk_avail = full[rbank];
  assign bank_cnt  = {1'b0, full[0]} + {1'b0, full[1]};

  assign wr_acc = wr_en && wr_ready;
  assign rd_acc = rd_en && blk_avail;
  assign wr_end = (wcnt == addrWIDTH'(DEPTH-1));
  assign rd_end = (rcnt == addrWIDTH'(DEPTH-1));

  // Scan order is fixed by zz_mode at the first read of a block.
  assign zz    = (rcnt == '0) ? zz_mode : zz_lat;
  assign raddr = (ZIGZAG && zz) ? zz_addr(rcnt) : rcnt;

  assign full_set = (wr_acc && wr_end) ? (2'b01 << wbank) : 2'b00;
  assign full_clr = (rd_acc && rd_end) ? (2'b01 << rbank) : 2'b00;

  // Write side: bank storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wbank, wcnt}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full        <= 2'b00;
      wbank       <= 1'b0;
      wcnt        <= '0;
      wr_overflow <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (wr_acc) begin
        wcnt <= wr_end ? '0 : wcnt + 1'b1;
        if (wr_end) wbank <= ~wbank;
      end else if (wr_en) begin
        wr_overflow <= 1'b1;
      end
    end
  end

  // Read side: one-cycle registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbank    <= 1'b0;
      rcnt     <= '0;
      zz_lat   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      rd_last  <= rd_acc && rd_end;
      if (rd_acc) begin
        rd_data <= mem[{rbank, raddr}];
        if (rcnt == '0) zz_lat <= zz_mode;
        rcnt <= rd_end ? '0 : rcnt + 1'b1;
        if (rd_end) rbank <= ~rbank;
      end
    end
  end

endmodule
